// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : dcache_pkg                                                    |
// | Purpose : Shared types and width helpers for the data-cache responder.  |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  localparam int c_WORD_W    = 32;
  localparam int c_DEF_LINES = 4;
  localparam int c_DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } dcache_state_e;

  // Byte-offset bits within a line (word select plus the two byte bits).
  function automatic int offBits(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int idxBits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagBits(input int lines, input int words);
    return c_WORD_W - offBits(words) - idxBits(lines);
  endfunction

  function automatic int lineBits(input int words);
    return c_WORD_W * words;
  endfunction

  localparam int c_OFF    = offBits(c_DEF_WORDS);
  localparam int c_IDX    = idxBits(c_DEF_LINES);
  localparam int c_TAG    = tagBits(c_DEF_LINES, c_DEF_WORDS);
  localparam int c_LINE_W = lineBits(c_DEF_WORDS);

endpackage

`default_nettype wire

// File: rtl/dcache_responder_if.sv
// ---------------------------------------------------------------------------
// | Module  : dcache_responder_if                                           |
// | Purpose : Core request bus plus line-wide memory handshake bundle.      |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

interface dcache_responder_if #(
  parameter int WORDS = 4
);
  import dcache_pkg::*;

  // Core side
  logic [c_WORD_W-1:0]       addr;
  logic [c_WORD_W-1:0]       wdata;
  logic                      we;
  logic                      re;
  logic [c_WORD_W-1:0]       rdata;
  logic                      dhit;

  // Memory side
  logic                      mem_req;
  logic                      mem_we;
  logic [c_WORD_W-1:0]       mem_addr;
  logic [c_WORD_W*WORDS-1:0] mem_wdata;
  logic [c_WORD_W*WORDS-1:0] mem_rdata;
  logic                      mem_ready;

  // The responder itself
  modport slave (
    input  addr, wdata, we, re, mem_rdata, mem_ready,
    output rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
  );

  // The environment: core plus main memory
  modport master (
    output addr, wdata, we, re, mem_rdata, mem_ready,
    input  rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ---------------------------------------------------------------------------
// | Module  : dcache_line_store                                             |
// | Purpose : Valid/dirty/tag/data flop arrays with one read port, a word   |
// |           write port and a full-line fill port.                        |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_line_store
  import dcache_pkg::*;
#(
  parameter  int LINES    = 4,
  parameter  int WORDS    = 4,
  localparam int c_IDXW   = idxBits(LINES),
  localparam int c_TAGW   = tagBits(LINES, WORDS),
  localparam int c_WSEL   = $clog2(WORDS),
  localparam int c_LINEW  = lineBits(WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  // Shared line/word select (the core holds its address stable on a miss)
  input  logic [c_IDXW-1:0]   index,
  input  logic [c_WSEL-1:0]   word,
  // Read port
  output logic                rdValid,
  output logic                rdDirty,
  output logic [c_TAGW-1:0]   rdTag,
  output logic [c_WORD_W-1:0] rdWord,
  output logic [c_LINEW-1:0]  rdLine,
  // Word write port (store hit)
  input  logic                wordWe,
  input  logic [c_WORD_W-1:0] wordData,
  // Line fill port (refill completion)
  input  logic                lineWe,
  input  logic [c_LINEW-1:0]  lineData,
  input  logic [c_TAGW-1:0]   lineTag,
  // Writeback completion
  input  logic                dirtyClr
);

  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [c_TAGW-1:0]   r_tag  [LINES];
  logic [c_LINEW-1:0]  r_data [LINES];

  // Status bits: reset clears them, a fill makes the line clean and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (lineWe) begin
      r_valid[index] <= 1'b1;
      r_dirty[index] <= 1'b0;
    end else if (wordWe) begin
      r_dirty[index] <= 1'b1;
    end else if (dirtyClr) begin
      r_dirty[index] <= 1'b0;
    end
  end

  // Tag and data payload; writes are suppressed while reset is asserted so an
  // aborted refill never lands in the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (lineWe) begin
        r_tag[index]  <= lineTag;
        r_data[index] <= lineData;
      end else if (wordWe) begin
        r_data[index][c_WORD_W*int'(word) +: c_WORD_W] <= wordData;
      end
    end
  end

  assign rdValid = r_valid[index];
  assign rdDirty = r_dirty[index];
  assign rdTag   = r_tag[index];
  assign rdLine  = r_data[index];
  assign rdWord  = r_data[index][c_WORD_W*int'(word) +: c_WORD_W];

endmodule

`default_nettype wire

// File: rtl/dcache_responder.sv
// ---------------------------------------------------------------------------
// | Module  : dcache_responder                                              |
// | Purpose : Direct-mapped write-back write-allocate data cache serving    |
// |           the multicycle core, with a line-wide memory handshake.       |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_responder
  import dcache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  dcache_responder_if.slave  bus
);

  localparam int c_OFFW  = offBits(WORDS);
  localparam int c_IDXW  = idxBits(LINES);
  localparam int c_TAGW  = tagBits(LINES, WORDS);
  localparam int c_WSEL  = $clog2(WORDS);
  localparam int c_LINEW = lineBits(WORDS);

  // Address split
  logic [c_TAGW-1:0]   w_tag;
  logic [c_IDXW-1:0]   w_index;
  logic [c_WSEL-1:0]   w_word;
  logic                w_unusedAddrBits;

  assign w_tag            = bus.addr[c_WORD_W-1 -: c_TAGW];
  assign w_index          = bus.addr[c_OFFW +: c_IDXW];
  assign w_word           = bus.addr[2 +: c_WSEL];
  assign w_unusedAddrBits = ^bus.addr[1:0];

  // Line store read side
  logic                w_lineValid;
  logic                w_lineDirty;
  logic [c_TAGW-1:0]   w_lineTag;
  logic [c_WORD_W-1:0] w_readWord;
  logic [c_LINEW-1:0]  w_victimLine;

  logic                w_req;
  logic                w_hit;

  assign w_req = bus.re | bus.we;
  assign w_hit = w_lineValid & (w_lineTag == w_tag);

  // FSM and registered memory-side outputs
  dcache_state_e       r_state,     w_stateNext;
  logic                r_memReq,    w_memReqNext;
  logic                r_memWe,     w_memWeNext;
  logic [c_WORD_W-1:0] r_memAddr,   w_memAddrNext;
  logic [c_LINEW-1:0]  r_memWdata,  w_memWdataNext;

  logic                w_dhit;
  logic                w_wordWe;
  logic                w_lineWe;
  logic                w_dirtyClr;

  dcache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .index    (w_index),
    .word     (w_word),
    .rdValid  (w_lineValid),
    .rdDirty  (w_lineDirty),
    .rdTag    (w_lineTag),
    .rdWord   (w_readWord),
    .rdLine   (w_victimLine),
    .wordWe   (w_wordWe),
    .wordData (bus.wdata),
    .lineWe   (w_lineWe),
    .lineData (bus.mem_rdata),
    .lineTag  (w_tag),
    .dirtyClr (w_dirtyClr)
  );

  // State and memory-request registers; reset aborts any open transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_memReq   <= w_memReqNext;
      r_memWe    <= w_memWeNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
    end
  end

  // Next-state, hit/stall flag, array write strobes and next memory request.
  always_comb begin
    w_stateNext    = r_state;
    w_memReqNext   = r_memReq;
    w_memWeNext    = r_memWe;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_dhit         = 1'b0;
    w_wordWe       = 1'b0;
    w_lineWe       = 1'b0;
    w_dirtyClr     = 1'b0;

    case (r_state)
      IDLE: begin
        w_dhit = !w_req || w_hit;
        if (w_req && w_hit) begin
          // A store wins over a simultaneous load.
          w_wordWe = bus.we;
        end else if (w_req) begin
          w_memReqNext = 1'b1;
          if (w_lineValid && w_lineDirty) begin
            // Evict the victim first; its address comes from the stored tag.
            w_stateNext    = WB;
            w_memWeNext    = 1'b1;
            w_memAddrNext  = {w_lineTag, w_index, {c_OFFW{1'b0}}};
            w_memWdataNext = w_victimLine;
          end else begin
            w_stateNext   = REFILL;
            w_memWeNext   = 1'b0;
            w_memAddrNext = {w_tag, w_index, {c_OFFW{1'b0}}};
          end
        end
      end

      WB: begin
        if (bus.mem_ready) begin
          // Chain straight into the refill so mem_req stays asserted.
          w_dirtyClr    = 1'b1;
          w_stateNext   = REFILL;
          w_memReqNext  = 1'b1;
          w_memWeNext   = 1'b0;
          w_memAddrNext = {w_tag, w_index, {c_OFFW{1'b0}}};
        end
      end

      REFILL: begin
        if (bus.mem_ready) begin
          w_lineWe     = 1'b1;
          w_stateNext  = IDLE;
          w_memReqNext = 1'b0;
          w_memWeNext  = 1'b0;
        end
      end

      default: begin
        w_stateNext  = IDLE;
        w_memReqNext = 1'b0;
        w_memWeNext  = 1'b0;
      end
    endcase
  end

  assign bus.dhit      = w_dhit;
  assign bus.rdata     = (r_state == IDLE && w_hit) ? w_readWord : '0;
  assign bus.mem_req   = r_memReq;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

endmodule

`default_nettype wire

// File: tb/tb_dcache_responder.sv
// ---------------------------------------------------------------------------
// | Module  : tb_dcache_responder                                           |
// | Purpose : Self-checking bench; plays core and main memory, predicts     |
// |           results from a flat-memory view plus a tag directory.         |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dcache_responder_if #(.WORDS(4)) bus ();

  dcache_responder #(
    .LINES (4),
    .WORDS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nAsserts = 0;
  int nFails   = 0;

  // gold: what the core should read back; backMem: what main memory holds.
  logic [31:0] gold    [int unsigned];
  logic [31:0] backMem [int unsigned];
  bit          mValid  [4];
  bit          mDirty  [4];
  int unsigned mTag    [4];

  function automatic logic [31:0] initWord(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] goldRd(input int unsigned a);
    int unsigned wa = a / 4;
    return gold.exists(wa) ? gold[wa] : initWord(wa);
  endfunction

  function automatic logic [31:0] backRd(input int unsigned a);
    int unsigned wa = a / 4;
    return backMem.exists(wa) ? backMem[wa] : initWord(wa);
  endfunction

  function automatic logic [127:0] goldLine(input int unsigned base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = goldRd(base + 4*i);
    return l;
  endfunction

  function automatic logic [127:0] backLine(input int unsigned base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = backRd(base + 4*i);
    return l;
  endfunction

  function automatic bit modelHit(input int unsigned a);
    int unsigned line = a / 16;
    return mValid[line % 4] && (mTag[line % 4] == line / 4);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    gold = backMem;  // dirty lines are lost on reset
  endtask

  // One memory transaction as seen from the memory side: check the request
  // each cycle, raise mem_ready after lat cycles, then retire it.
  task automatic memPhase(input bit isWb, input int unsigned base, input int lat);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk); #1;
      chk("memReq",  bus.mem_req,  1'b1);
      chk("memWe",   bus.mem_we,   isWb);
      chk("memAddr", bus.mem_addr, base);
      chk("stall",   bus.dhit,     1'b0);
      if (isWb && c == 0) chk("wbLine", bus.mem_wdata, goldLine(base));
      bus.mem_ready = (c == lat);
      if (!isWb && c == lat) bus.mem_rdata = backLine(base);
      else bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (isWb)
      for (int i = 0; i < 4; i++) backMem[(base + 4*i) / 4] = goldRd(base + 4*i);
  endtask

  // One core access, including any miss handling, until the hit edge.
  task automatic access(input int unsigned a, input logic doRe, input logic doWe,
                        input logic [31:0] d, input int lat);
    int unsigned line = a / 16;
    int unsigned idx  = line % 4;
    int unsigned tag  = line / 4;
    bit expHit;
    @(negedge clk);
    bus.addr      = a;
    bus.re        = doRe;
    bus.we        = doWe;
    bus.wdata     = d;
    bus.mem_ready = 1'($urandom_range(0, 1));
    #1;
    expHit = modelHit(a);
    chk("dhitFirst", bus.dhit, expHit);
    if (!expHit) begin
      chk("rdataMiss", bus.rdata, 32'h0);
      if (mValid[idx] && mDirty[idx]) memPhase(1'b1, (mTag[idx] * 4 + idx) * 16, lat);
      memPhase(1'b0, line * 16, lat);
      mValid[idx] = 1'b1;
      mTag[idx]   = tag;
      mDirty[idx] = 1'b0;
      @(negedge clk); #1;
      chk("dhitAfterFill", bus.dhit,    1'b1);
      chk("reqDropped",    bus.mem_req, 1'b0);
    end else begin
      chk("noReqOnHit", bus.mem_req, 1'b0);
    end
    if (doWe) begin
      @(posedge clk);
      gold[a / 4] = d;
      mDirty[idx] = 1'b1;
    end else begin
      chk("loadData", bus.rdata, goldRd(a));
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.re        = 1'b0;
    bus.we        = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("idleDhit",  bus.dhit,    1'b1);
    chk("idleReq",   bus.mem_req, 1'b0);
    chk("idleRdata", bus.rdata,   modelHit(bus.addr) ? goldRd(bus.addr) : 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int          op;

    reset         = 1'b1;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstDhit",   bus.dhit,      1'b1);
    chk("rstReq",    bus.mem_req,   1'b0);
    chk("rstWe",     bus.mem_we,    1'b0);
    chk("rstAddr",   bus.mem_addr,  32'h0);
    chk("rstWdata",  bus.mem_wdata, 128'h0);
    chk("rstRdata",  bus.rdata,     32'h0);

    // Directed: cold load, hit load, store hit, dirty conflict miss
    backMem[32'h40 / 4] = 32'h11;
    backMem[32'h44 / 4] = 32'h22;
    backMem[32'h48 / 4] = 32'h33;
    backMem[32'h4C / 4] = 32'h44;
    gold = backMem;
    access(32'h40,  1'b1, 1'b0, 32'h0, 3);
    access(32'h48,  1'b1, 1'b0, 32'h0, 0);
    access(32'h44,  1'b0, 1'b1, 32'hDEAD, 0);
    access(32'h44,  1'b1, 1'b0, 32'h0, 0);
    access(32'h140, 1'b1, 1'b0, 32'h0, 2);
    chk("wbLanded", backMem[32'h44 / 4], 32'hDEAD);
    access(32'h14C, 1'b1, 1'b1, 32'hBEEF, 0);
    access(32'h14C, 1'b1, 1'b0, 32'h0, 0);
    idle();

    // Directed: reset while a refill is outstanding
    @(negedge clk);
    bus.addr = 32'h2A0;
    bus.re   = 1'b1;
    bus.we   = 1'b0;
    #1;
    chk("abortMissDhit", bus.dhit, 1'b0);
    @(negedge clk); #1;
    chk("abortReqUp",  bus.mem_req,  1'b1);
    chk("abortAddrUp", bus.mem_addr, 32'h2A0);
    reset  = 1'b1;
    bus.re = 1'b0;
    @(negedge clk); #1;
    chk("abortReqDown", bus.mem_req, 1'b0);
    chk("abortDhit",    bus.dhit,    1'b1);
    reset = 1'b0;
    modelReset();
    access(32'h2A0, 1'b1, 1'b0, 32'h0, 1);
    access(32'h14C, 1'b1, 1'b0, 32'h0, 1);

    // Randomized traffic over a small footprint to force conflicts
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_FC00;
      op = $urandom_range(0, 3);
      case (op)
        0, 3: access(a, 1'b1, 1'b0, 32'h0, $urandom_range(0, 3));
        1:    access(a, 1'b0, 1'b1, $urandom, $urandom_range(0, 3));
        default: access(a, 1'b1, 1'b1, $urandom, $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side memory responder for the multicycle RISC-V core.
- Serves the core's load/store requests (address = ALUOut, WriteData, MemWrite, LoadM) and returns ReadData plus the dhit stall flag.
- Direct-mapped, write-back, write-allocate cache. A line-wide refill/writeback handshake connects it to main memory.

Parameters:
- LINES, 4, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).
- Derived, not overridable: OFF = log2(WORDS) + 2 address bits; IDX = log2(LINES) index bits; TAG = 32 - OFF - IDX.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  core byte address; bits [1:0] ignored (word access only).
- wdata  in  32  core store data.
- we  in  1  core store request (MemWrite).
- re  in  1  core load request (LoadM).
- rdata  out  32  load data to core (ReadData).
- dhit  out  1  1 = request satisfied this cycle / no stall.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  32  line-aligned address (low OFF bits zero).
- mem_wdata  out  32*WORDS  victim line, word 0 in the LSBs.
- mem_rdata  in  32*WORDS  refill line, word 0 in the LSBs.
- mem_ready  in  1  memory completes the transaction when sampled high with mem_req.

Behaviour:
- Address split: tag = addr[31:OFF+IDX], index = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2].
- Storage: per-line valid, dirty, tag and data registers, all flops.
- Reset:
  - Clears every valid and dirty bit; state = IDLE.
  - Outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0.
  - dhit = 1 while re = we = 0.
  - Reset during WB or REFILL aborts the transaction: mem_req drops on the next cycle and no line is written.
- Request: req = re | we. If re and we are both high, we wins and the access is treated as a store.
- Hit: hit = valid[index] & (tag_store[index] == tag).
- dhit (combinational):
  - IDLE: !req | hit.
  - Any other state: 0.
- rdata (combinational): data[index][word] whenever state = IDLE and hit; otherwise 0.
- Store hit: at the edge where dhit = 1 and we = 1, write wdata into data[index][word] and set dirty[index].
- Core contract: addr, wdata, re and we stay stable while dhit = 0.
- FSM states: IDLE, WB, REFILL.
  - IDLE -> WB on req & !hit & valid[index] & dirty[index].
  - IDLE -> REFILL on req & !hit & !(valid & dirty).
  - WB:
    - Drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line.
    - On mem_ready: clear dirty, go to REFILL.
  - REFILL:
    - Drive mem_req = 1, mem_we = 0, mem_addr = {tag, index, 0}.
    - On mem_ready: load mem_rdata into the line, set valid, clear dirty, load tag, go to IDLE.
  - Back in IDLE the access now hits: dhit = 1 one cycle after the mem_ready edge. A store then updates the word and sets dirty on that edge.
- Memory handshake:
  - mem_req and mem_addr/mem_wdata are registered and held constant until mem_ready is sampled.
  - mem_req drops the cycle after completion unless a new transaction starts immediately (WB -> REFILL keeps mem_req high).
  - Memory latency is unbounded; mem_ready while mem_req = 0 is ignored.
- Miss latency:
  - Clean miss: 1 cycle + memory latency.
  - Dirty miss: adds one full writeback transaction.
- A request dropped mid-miss is not legal; the responder completes the miss regardless.

Decomposition:
- Shared package dcache_pkg: FSM state encoding (IDLE = 2'd0, WB = 2'd1, REFILL = 2'd2), width helper constants for OFF/IDX/TAG, line-width constant 32*WORDS.
- One natural sub-module: dcache_line_store. It holds the valid/dirty/tag/data arrays, with a read port (index, word) and two write ports (word write, line fill) selected by the FSM.

Test Plan:
- Reset, then re = we = 0 -> dhit = 1, mem_req = 0, rdata = 0; any valid read-back via a later access misses.
- Cold load re = 1, addr = 0x40 -> dhit = 0. Next cycle mem_req = 1, mem_we = 0, mem_addr = 0x40. mem_ready pulses after 3 cycles with words {0x11,0x22,0x33,0x44} -> next cycle dhit = 1, rdata = 0x11. A following load of 0x48 gives dhit = 1 immediately, rdata = 0x33, no mem_req.
- Store hit we = 1, addr = 0x44, wdata = 0xDEAD -> dhit = 1 same cycle. A following load of 0x44 returns 0xDEAD; dirty[0] set.
- Conflict load addr = 0x140 (index 0, new tag) after the store:
  - mem_req with mem_we = 1, mem_addr = 0x40, mem_wdata words {0x11,0xDEAD,0x33,0x44}.
  - After mem_ready, mem_we = 0 and mem_addr = 0x140 with mem_req held high.
  - After the second mem_ready, dhit = 1 with the new word.
- Simultaneous re = we = 1 on a hit -> treated as a store: word updated, dirty set.
- Assert reset during REFILL with mem_ready low -> next cycle mem_req = 0, state IDLE. Re-accessing the same address misses again and issues a fresh refill.
